ud_counter_param: RTL

Parametrised up/down modulo counter that replaces the fixed 4-bit up/down counter. It adds configurable width and modulus, count enable, synchronous load, wrap-or-saturate mode, a terminal-count pulse and a sticky wrap flag. It keeps the 7-segment hex display of the low nibble for board bring-up. It sits between the push-button/switch front end and the display or downstream control logic.

---
 rtl/ud_counter_pkg.sv | 31 +++
 rtl/seg7_hex.sv | 37 +++
 rtl/ud_counter_param.sv | 116 +++++++++++
 3 files changed

// File: rtl/ud_counter_pkg.sv
// ---------------------------------------------------------------------------
// ud_counter_pkg
// Shared constants for the up/down counter and the hex segment decoder.
//   SEG_0..SEG_F : segment patterns {a,b,c,d,e,f,g}, active-high
//   SEG_BLANK    : all segments off
//   DIR_UP/DOWN  : values of the direction input
// ---------------------------------------------------------------------------
package ud_counter_pkg;

   localparam logic [6:0] SEG_0     = 7'b1111110;
   localparam logic [6:0] SEG_1     = 7'b0110000;
   localparam logic [6:0] SEG_2     = 7'b1101101;
   localparam logic [6:0] SEG_3     = 7'b1111001;
   localparam logic [6:0] SEG_4     = 7'b0110011;
   localparam logic [6:0] SEG_5     = 7'b1011011;
   localparam logic [6:0] SEG_6     = 7'b1011111;
   localparam logic [6:0] SEG_7     = 7'b1110000;
   localparam logic [6:0] SEG_8     = 7'b1111111;
   localparam logic [6:0] SEG_9     = 7'b1111011;
   localparam logic [6:0] SEG_A     = 7'b1110111;
   localparam logic [6:0] SEG_B     = 7'b0011111;
   localparam logic [6:0] SEG_C     = 7'b1001110;
   localparam logic [6:0] SEG_D     = 7'b0111101;
   localparam logic [6:0] SEG_E     = 7'b1001111;
   localparam logic [6:0] SEG_F     = 7'b1000111;
   localparam logic [6:0] SEG_BLANK = 7'b0000000;

   localparam logic DIR_UP   = 1'b1;
   localparam logic DIR_DOWN = 1'b0;

endpackage

// File: rtl/seg7_hex.sv
// ---------------------------------------------------------------------------
// seg7_hex
// Combinational hex (0..F) to 7-segment decoder.
//   i_hex [3:0] : value to show
//   o_seg [6:0] : segments {a,b,c,d,e,f,g}, active-high
// ---------------------------------------------------------------------------
module seg7_hex
   import ud_counter_pkg::*;
(
   input  logic [3:0] i_hex,
   output logic [6:0] o_seg
);

   always_comb begin
      o_seg = SEG_BLANK;
      case (i_hex)
         4'h0: o_seg = SEG_0;
         4'h1: o_seg = SEG_1;
         4'h2: o_seg = SEG_2;
         4'h3: o_seg = SEG_3;
         4'h4: o_seg = SEG_4;
         4'h5: o_seg = SEG_5;
         4'h6: o_seg = SEG_6;
         4'h7: o_seg = SEG_7;
         4'h8: o_seg = SEG_8;
         4'h9: o_seg = SEG_9;
         4'hA: o_seg = SEG_A;
         4'hB: o_seg = SEG_B;
         4'hC: o_seg = SEG_C;
         4'hD: o_seg = SEG_D;
         4'hE: o_seg = SEG_E;
         4'hF: o_seg = SEG_F;
         default: o_seg = SEG_BLANK;
      endcase
   end

endmodule

// File: rtl/ud_counter_param.sv
// ---------------------------------------------------------------------------
// ud_counter_param
// Parametrised up/down modulo counter with enable, synchronous load,
// wrap-or-saturate mode, terminal-count pulse, sticky wrap flag and a
// hex display of the low nibble.
//
// Parameters:
//   WIDTH   : counter width, 4..16
//   MODULUS : count range 0..MODULUS-1, 2..2^WIDTH
// Ports:
//   cp      : clock, rising edge
//   reset   : asynchronous reset, active-low
//   en      : count enable
//   x       : direction, 1 = up, 0 = down
//   load    : synchronous load of din (clamped to MODULUS-1)
//   din     : load value
//   sat     : 1 = saturate at the ends, 0 = wrap
//   out     : registered count
//   tc      : registered one-cycle pulse on each wrap
//   wrapped : sticky wrap flag, cleared by reset or load
//   display : 7-segment pattern of out[3:0]
// Build option:
//   UD_COUNTER_SEG_EN : when defined, seg7_hex drives display; otherwise
//                       display is tied to all-off.
// ---------------------------------------------------------------------------
module ud_counter_param
   import ud_counter_pkg::*;
#(
   parameter int WIDTH   = 4,
   parameter int MODULUS = 16
)
(
   input  logic             cp,
   input  logic             reset,
   input  logic             en,
   input  logic             x,
   input  logic             load,
   input  logic [WIDTH-1:0] din,
   input  logic             sat,
   output logic [WIDTH-1:0] out,
   output logic             tc,
   output logic             wrapped,
   output logic [6:0]       display
);

   // The count lives in a WIDTH+1 register so that MODULUS = 2^WIDTH never
   // aliases in the compare/increment path; the top bit is always zero.
   localparam logic [WIDTH:0] MAX_V = (WIDTH+1)'(MODULUS - 1);

   logic [WIDTH:0] r_cnt;
   logic           r_tc;
   logic           r_wrapped;

   logic [WIDTH:0] w_din;
   logic [WIDTH:0] w_din_clamp;
   logic [WIDTH:0] w_cnt_nxt;
   logic           w_tc_nxt;
   logic           w_wrapped_nxt;

   assign w_din       = {1'b0, din};
   assign w_din_clamp = (w_din > MAX_V) ? MAX_V : w_din;

   always_comb begin
      w_cnt_nxt     = r_cnt;
      w_tc_nxt      = 1'b0;
      w_wrapped_nxt = r_wrapped;
      if (load) begin
         w_cnt_nxt     = w_din_clamp;
         w_wrapped_nxt = 1'b0;
      end else if (en) begin
         if (x == DIR_UP) begin
            if (r_cnt < MAX_V) begin
               w_cnt_nxt = r_cnt + 1'b1;
            end else if (!sat) begin
               w_cnt_nxt     = '0;
               w_tc_nxt      = 1'b1;
               w_wrapped_nxt = 1'b1;
            end
         end else begin
            if (r_cnt != '0) begin
               w_cnt_nxt = r_cnt - 1'b1;
            end else if (!sat) begin
               w_cnt_nxt     = MAX_V;
               w_tc_nxt      = 1'b1;
               w_wrapped_nxt = 1'b1;
            end
         end
      end
   end

   always_ff @(posedge cp or negedge reset) begin
      if (!reset) begin
         r_cnt     <= '0;
         r_tc      <= 1'b0;
         r_wrapped <= 1'b0;
      end else begin
         r_cnt     <= w_cnt_nxt;
         r_tc      <= w_tc_nxt;
         r_wrapped <= w_wrapped_nxt;
      end
   end

   assign out     = r_cnt[WIDTH-1:0];
   assign tc      = r_tc;
   assign wrapped = r_wrapped;

`ifdef UD_COUNTER_SEG_EN
   seg7_hex u_seg7_hex (
      .i_hex (r_cnt[3:0]),
      .o_seg (display)
   );
`else
   assign display = SEG_BLANK;
`endif

endmodule
